// File: rtl/wsg_sound_engine.sv
// wsg_sound_engine: Namco WSG 3-voice wavetable generator, one voice per step, mixed mono sample out.
module wsg_sound_engine #(
  parameter int PIXEL_CLOCK = 39250000,
  parameter int STEP_RATE   = 72000
) (
  input  logic       clk_pixel,
  input  logic       reset_n,
  input  logic       wr_stb,
  input  logic [4:0] wr_addr,
  input  logic [3:0] wr_data,
  input  logic       sound_en,
  output logic       prom_rd,
  output logic [7:0] prom_addr,
  output logic       prom_sel,
  input  logic [3:0] prom_data,
  output logic [9:0] sample,
  output logic       sample_valid
);
  localparam int DIV = PIXEL_CLOCK / STEP_RATE;
  localparam int CW = $clog2(DIV);
  typedef enum logic [1:0] {IDLE, ADV, FETCH, MAC} state_t;
  state_t state, state_nxt;
  logic [3:0] regs [32];
  logic [19:0] phase [3];
  logic [CW-1:0] cnt;
  logic [1:0] v;
  logic [9:0] acc;
  logic tick;
  logic [4:0] b;
  logic [3:0] wave, vol_eff;
  logic [19:0] freq, phase_nxt;
  logic [4:0] d;
  logic [9:0] term;
  assign tick = cnt == CW'(DIV - 1);
  // register base for voice v is 5*v
  assign b = (v == 2'd0) ? 5'd0 : (v == 2'd1) ? 5'd5 : 5'd10;
  assign wave = regs[5'h05 + b];
  assign vol_eff = sound_en ? regs[5'h15 + b] : 4'h0;
  assign freq = {regs[5'h14 + b], regs[5'h13 + b], regs[5'h12 + b], regs[5'h11 + b],
                 (v == 2'd0) ? regs[5'h10] : 4'h0};
  assign phase_nxt = phase[v] + freq;
  // PROM nibble biased to signed -8..7; product truncated to 10-bit two's complement
  assign d = {1'b0, prom_data} - 5'd8;
  assign term = {6'd0, vol_eff} * {{5{d[4]}}, d};
  always_ff @(posedge clk_pixel or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = tick ? ADV : IDLE;
      ADV:     state_nxt = FETCH;
      FETCH:   state_nxt = MAC;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) regs[i] <= 4'h0;
      for (int i = 0; i < 3; i++) phase[i] <= 20'h0;
      cnt <= '0;
      v <= 2'd0;
      acc <= 10'd0;
      prom_rd <= 1'b0;
      prom_addr <= 8'h00;
      prom_sel <= 1'b0;
      sample <= 10'd0;
      sample_valid <= 1'b0;
    end else begin
      if (wr_stb) regs[wr_addr] <= wr_data;
      cnt <= tick ? '0 : cnt + 1'b1;
      prom_rd <= state == ADV;
      sample_valid <= 1'b0;
      if (state == ADV) begin
        phase[v] <= phase_nxt;
        prom_addr <= {wave[2:0], phase_nxt[17:13]};
        prom_sel <= wave[3];
      end
      if (state == MAC) begin
        if (v == 2'd2) begin
          sample <= acc + term;
          sample_valid <= 1'b1;
          acc <= 10'd0;
          v <= 2'd0;
        end else begin
          acc <= acc + term;
          v <= v + 2'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_wsg_sound_engine.sv
// tb_wsg_sound_engine: directed checks of the WSG engine with a registered PROM model (DIV = 10).
module tb_wsg_sound_engine;
  localparam int DIV = 10;
  logic clk_pixel = 1'b0;
  logic reset_n = 1'b0;
  logic wr_stb = 1'b0;
  logic [4:0] wr_addr = 5'd0;
  logic [3:0] wr_data = 4'd0;
  logic sound_en = 1'b0;
  logic prom_rd;
  logic [7:0] prom_addr;
  logic prom_sel;
  logic [3:0] prom_data = 4'd0;
  logic [9:0] sample;
  logic sample_valid;
  logic [3:0] prom_val = 4'd0;
  int passed = 0;
  int total = 0;
  int n;
  wsg_sound_engine #(.PIXEL_CLOCK(500), .STEP_RATE(50)) dut (
    .clk_pixel(clk_pixel), .reset_n(reset_n), .wr_stb(wr_stb), .wr_addr(wr_addr),
    .wr_data(wr_data), .sound_en(sound_en), .prom_rd(prom_rd), .prom_addr(prom_addr),
    .prom_sel(prom_sel), .prom_data(prom_data), .sample(sample), .sample_valid(sample_valid)
  );
  always #5 clk_pixel = ~clk_pixel;
  always @(posedge clk_pixel) if (prom_rd) prom_data <= prom_val;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
  endtask
  task automatic wr(input logic [4:0] a, input logic [3:0] dat);
    wr_stb = 1'b1;
    wr_addr = a;
    wr_data = dat;
    @(negedge clk_pixel);
    wr_stb = 1'b0;
  endtask
  task automatic wait_sv(output int c);
    c = 0;
    do begin
      @(negedge clk_pixel);
      c++;
    end while (!sample_valid && c < 4 * DIV + 10);
    chk("sample_valid_seen", sample_valid, 1);
  endtask
  task automatic wait_prom(output int c);
    c = 0;
    do begin
      @(negedge clk_pixel);
      c++;
    end while (!prom_rd && c < 3 * DIV + 4);
    chk("prom_rd_seen", prom_rd, 1);
  endtask
  task automatic do_reset;
    @(negedge clk_pixel);
    reset_n = 1'b0;
    repeat (2) @(negedge clk_pixel);
    reset_n = 1'b1;
  endtask
  initial begin
    // reset held with inputs toggling
    for (int i = 0; i < 4; i++) begin
      wr_stb = 1'b1;
      wr_addr = 5'($urandom_range(0, 31));
      wr_data = 4'($urandom_range(0, 15));
      sound_en = ~sound_en;
      @(negedge clk_pixel);
      chk("reset_outputs", {prom_rd, prom_addr, prom_sel, sample, sample_valid}, 0);
    end
    wr_stb = 1'b0;
    sound_en = 1'b0;
    reset_n = 1'b1;
    wait_prom(n);
    chk("first_prom_rd_cycle", n + 1, DIV + 2);
    // voice 0 only, PROM full scale
    do_reset;
    sound_en = 1'b1;
    prom_val = 4'hF;
    wr(5'h15, 4'hF);
    wait_sv(n);
    wait_sv(n);
    chk("v0_sample", sample, 10'h069);
    chk("strobe_period", n, 3 * DIV);
    @(negedge clk_pixel);
    chk("strobe_one_cycle", sample_valid, 0);
    repeat (14) @(negedge clk_pixel);
    chk("sample_hold", sample, 10'h069);
    wait_sv(n);
    chk("v0_sample_again", sample, 10'h069);
    // all voices full volume, PROM minimum
    wr(5'h1A, 4'hF);
    wr(5'h1F, 4'hF);
    prom_val = 4'h0;
    wait_sv(n);
    wait_sv(n);
    chk("all_min_sample", sample, 10'h298);
    sound_en = 1'b0;
    wait_sv(n);
    chk("sound_disabled", sample, 10'h000);
    // phase stepping and wave select
    do_reset;
    wr(5'h13, 4'h2);
    wr(5'h05, 4'hB);
    for (int a = 6'h16; a <= 6'h19; a++) wr(5'(a), 4'hF);
    for (int k = 0; k < 99; k++) begin
      wait_prom(n);
      if (k % 3 == 0) chk("v0_fetch", {prom_sel, prom_addr}, 9'h160 | 9'((k / 3 + 1) % 32));
      else if (k % 3 == 1) chk("v1_fetch", {prom_sel, prom_addr}, 9'h01F);
      else chk("v2_fetch", {prom_sel, prom_addr}, 9'h000);
    end
    // volume written during the voice's own fetch
    do_reset;
    sound_en = 1'b1;
    prom_val = 4'hF;
    wait_prom(n);
    wr(5'h15, 4'hF);
    wait_sv(n);
    chk("vol_write_in_fetch", sample, 10'h069);
    // reset during voice 1 MAC, with voice 0 term already accumulated
    wait_prom(n);
    wait_prom(n);
    @(negedge clk_pixel);
    reset_n = 1'b0;
    #1;
    chk("midmac_reset_out", {sample, sample_valid, prom_rd}, 0);
    @(negedge clk_pixel);
    reset_n = 1'b1;
    prom_val = 4'h0;
    wr(5'h1A, 4'hF);
    n = 1;
    do begin
      @(negedge clk_pixel);
      n++;
    end while (!sample_valid && n < 4 * DIV + 10);
    chk("first_strobe_cycle", n + 1, 3 * DIV + 4);
    chk("post_reset_sample", sample, 10'h388);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
